// File: rtl/seg14_pattern_decoder.sv
// Recovers 4-bit letter codes from active-low 14-segment patterns, buffers them in a
// small FIFO behind valid/ready, and flags every completed "NTHUEE" word.
module seg14_pattern_decoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [14:0]      pattern_in,
  input  logic             pattern_valid,
  output logic             pattern_ready,
  output logic [3:0]       code_out,
  output logic             code_valid,
  input  logic             code_ready,
  output logic             word_match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5} state_t;

  function automatic logic [3:0] decode_pattern(input logic [14:0] p);
    case (p)
      15'b100100110111101: decode_pattern = 4'd0;
      15'b011111111011011: decode_pattern = 4'd1;
      15'b100100001111111: decode_pattern = 4'd2;
      15'b100000111111111: decode_pattern = 4'd3;
      15'b011000001111111: decode_pattern = 4'd4;
      15'b111111111111111: decode_pattern = 4'd15;
      default:             decode_pattern = 4'd14;
    endcase
  endfunction

  logic [3:0]       mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]       head_q, head_d;
  state_t           state_q, state_d;
  logic             word_match_q, word_match_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_flag_q, err_flag_d;

  logic        fifo_full_s, fifo_empty_s, push_s, pop_s;
  logic [3:0]  dec_s, exp_code_s;
  logic [AW:0] count_s, count_after_pop_s;
  state_t      adv_state_s;

  assign dec_s        = decode_pattern(pattern_in);
  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_s  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign push_s       = pattern_valid && !fifo_full_s;
  assign pop_s        = !fifo_empty_s && code_ready;
  assign count_s           = wr_ptr_q - rd_ptr_q;
  assign count_after_pop_s = count_s - (AW + 1)'(pop_s);

  // Head register tracks the entry that will be at the FIFO head after this edge.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW + 1)'(push_s);
    rd_ptr_d = rd_ptr_q + (AW + 1)'(pop_s);
    head_d   = head_q;
    if (push_s && (count_after_pop_s == '0)) begin
      head_d = dec_s;
    end else if (wr_ptr_d != rd_ptr_d) begin
      head_d = mem_q[rd_ptr_d[AW-1:0]];
    end else begin
      head_d = head_q;
    end
  end

  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    if (push_s && (dec_s == 4'd14)) begin
      err_flag_d = 1'b1;
      if (err_cnt_q != {CNT_W{1'b1}}) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      err_flag_d = err_flag_q;
    end
  end

  // Recogniser: expected code and successor for each partial-match state.
  always_comb begin
    state_d      = state_q;
    word_match_d = 1'b0;
    exp_code_s   = 4'd0;
    adv_state_s  = S1;
    case (state_q)
      S0:      begin exp_code_s = 4'd0; adv_state_s = S1; end
      S1:      begin exp_code_s = 4'd1; adv_state_s = S2; end
      S2:      begin exp_code_s = 4'd2; adv_state_s = S3; end
      S3:      begin exp_code_s = 4'd3; adv_state_s = S4; end
      S4:      begin exp_code_s = 4'd4; adv_state_s = S5; end
      S5:      begin exp_code_s = 4'd4; adv_state_s = S0; end
      default: begin exp_code_s = 4'd0; adv_state_s = S1; end
    endcase
    if (push_s) begin
      if (dec_s == exp_code_s) begin
        state_d      = adv_state_s;
        word_match_d = (state_q == S5);
      end else if (dec_s == 4'd0) begin
        state_d = S1;
      end else begin
        state_d = S0;
      end
    end else begin
      state_d = state_q;
    end
    match_cnt_d = match_cnt_q + CNT_W'(word_match_d);
  end

  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= dec_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      head_q       <= 4'd15;
      state_q      <= S0;
      word_match_q <= 1'b0;
      match_cnt_q  <= '0;
      err_cnt_q    <= '0;
      err_flag_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      head_q       <= head_d;
      state_q      <= state_d;
      word_match_q <= word_match_d;
      match_cnt_q  <= match_cnt_d;
      err_cnt_q    <= err_cnt_d;
      err_flag_q   <= err_flag_d;
    end
  end

  assign pattern_ready = !fifo_full_s;
  assign code_valid    = !fifo_empty_s;
  assign code_out      = head_q;
  assign word_match    = word_match_q;
  assign match_cnt     = match_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign err_flag      = err_flag_q;

endmodule

// File: tb/tb_seg14_pattern_decoder.sv
// Scoreboard bench: the driver queues hand-computed codes on every accept and a
// negedge monitor pops and compares them whenever the DUT hands out a code.
module tb_seg14_pattern_decoder;

  localparam logic [14:0] P_N = 15'b100100110111101;
  localparam logic [14:0] P_T = 15'b011111111011011;
  localparam logic [14:0] P_H = 15'b100100001111111;
  localparam logic [14:0] P_U = 15'b100000111111111;
  localparam logic [14:0] P_E = 15'b011000001111111;
  localparam logic [14:0] P_B = 15'h7FFF;
  localparam logic [14:0] P_X = 15'h0000;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] pattern_in = 15'h7FFF;
  logic        pattern_valid = 1'b0;
  logic        pattern_ready;
  logic [3:0]  code_out;
  logic        code_valid;
  logic        code_ready = 1'b0;
  logic        word_match;
  logic [7:0]  match_cnt;
  logic [7:0]  err_cnt;
  logic        err_flag;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   wm_seen = 0;
  int   pops = 0;
  bit   lat_chk = 1'b0;

  seg14_pattern_decoder #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .pattern_in(pattern_in), .pattern_valid(pattern_valid), .pattern_ready(pattern_ready),
    .code_out(code_out), .code_valid(code_valid), .code_ready(code_ready),
    .word_match(word_match), .match_cnt(match_cnt), .err_cnt(err_cnt), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a code is consumed at the next edge whenever valid and ready are both high.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (word_match) wm_seen++;
      if (code_valid && code_ready) begin
        pops++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_code got %0d expected none queued", code_out);
        end else begin
          e = exp_q.pop_front();
          if (code_out !== e.code) begin
            errors++;
            $display("FAIL code_out got %0d expected %0d", code_out, e.code);
          end
          if (lat_chk) begin
            checks++;
            if (cyc != e.cyc + 1) begin
              errors++;
              $display("FAIL code_latency got cycle %0d expected %0d", cyc, e.cyc + 1);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the pattern.
  task automatic send(input logic [14:0] p, input logic [3:0] code);
    int n = 0;
    exp_t e;
    pattern_in    = p;
    pattern_valid = 1'b1;
    while (!pattern_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", n, 0);
    end else begin
      e.code = code;
      e.cyc  = cyc;
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    pattern_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || code_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", int'(n >= 100), 0);
  endtask

  initial begin
    int wm_base;
    int pop_base;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_code_valid", code_valid, 0);
    chk("rst_pattern_ready", pattern_ready, 1);
    chk("rst_code_out", code_out, 15);
    chk("rst_word_match", word_match, 0);
    chk("rst_match_cnt", match_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_err_flag", err_flag, 0);

    // Stream one word with the consumer always ready.
    code_ready = 1'b1;
    lat_chk    = 1'b1;
    send(P_N, 4'd0); send(P_T, 4'd1); send(P_H, 4'd2);
    send(P_U, 4'd3); send(P_E, 4'd4); send(P_E, 4'd4);
    chk("t1_word_match_pulse", word_match, 1);
    @(posedge clk); #1;
    chk("t1_word_match_clear", word_match, 0);
    drain();
    chk("t1_match_cnt", match_cnt, 1);
    chk("t1_wm_seen", wm_seen, 1);
    chk("t1_err_flag", err_flag, 0);
    chk("t1_empty_hold_code", code_out, 4);
    chk("t1_empty_valid", code_valid, 0);

    // Backpressure: fill the FIFO, then release the consumer.
    lat_chk    = 1'b0;
    code_ready = 1'b0;
    pop_base   = pops;
    wm_base    = wm_seen;
    send(P_N, 4'd0); send(P_T, 4'd1); send(P_H, 4'd2); send(P_U, 4'd3);
    chk("t2_full_ready", pattern_ready, 0);
    chk("t2_head_code", code_out, 0);
    fork
      begin
        send(P_E, 4'd4);
        send(P_B, 4'd15);
      end
      begin
        repeat (3) begin @(posedge clk); #1; end
        chk("t2_still_full", pattern_ready, 0);
        code_ready = 1'b1;
      end
    join
    drain();
    chk("t2_pop_count", pops - pop_base, 6);
    chk("t2_no_match", wm_seen - wm_base, 0);

    // Error and blank patterns interleaved with a broken word.
    lat_chk = 1'b1;
    wm_base = wm_seen;
    send(P_X, 4'd14); send(P_N, 4'd0); send(P_T, 4'd1); send(P_H, 4'd2);
    send(P_B, 4'd15); send(P_U, 4'd3); send(P_E, 4'd4); send(P_E, 4'd4);
    drain();
    chk("t3_err_cnt", err_cnt, 1);
    chk("t3_err_flag", err_flag, 1);
    chk("t3_no_match", wm_seen - wm_base, 0);
    chk("t3_match_cnt", match_cnt, 1);

    // A repeated N restarts the word at the N-seen state.
    wm_base = wm_seen;
    send(P_N, 4'd0); send(P_N, 4'd0); send(P_T, 4'd1); send(P_H, 4'd2);
    send(P_U, 4'd3); send(P_E, 4'd4); send(P_E, 4'd4);
    drain();
    chk("t4_one_match", wm_seen - wm_base, 1);
    chk("t4_match_cnt", match_cnt, 2);

    // Reset with three codes buffered and a partial NTHU match.
    lat_chk = 1'b0;
    send(P_N, 4'd0);
    @(posedge clk); #1;
    code_ready = 1'b0;
    send(P_T, 4'd1); send(P_H, 4'd2); send(P_U, 4'd3);
    chk("t5_buffered_valid", code_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk("t5_code_valid", code_valid, 0);
    chk("t5_pattern_ready", pattern_ready, 1);
    chk("t5_code_out", code_out, 15);
    chk("t5_match_cnt", match_cnt, 0);
    chk("t5_err_cnt", err_cnt, 0);
    chk("t5_err_flag", err_flag, 0);
    code_ready = 1'b1;
    wm_base = wm_seen;
    send(P_E, 4'd4); send(P_E, 4'd4);
    drain();
    chk("t5_no_match", wm_seen - wm_base, 0);
    chk("t5_match_cnt_after", match_cnt, 0);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      send(P_X, 4'd14);
      if (i == 254) chk("t6_err_cnt_255", err_cnt, 255);
    end
    drain();
    chk("t6_err_cnt_sat", err_cnt, 255);
    chk("t6_err_flag", err_flag, 1);
    chk("t6_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
